dcache_controller: RTL and testbench
====================================

# dcache_controller

Parametrised write-back data-cache controller FSM, the next generation of the team's single-word-refill instruction-cache controller. It adds multi-word block transfers with an internal beat counter, dirty-line write-back before allocation, dirty-aware CLFLUSH, and a selectable write-allocate or write-around store-miss policy. It sits between the pipeline request port and the L2 request port and drives the data-cache datapath (tag/valid/dirty arrays, data RAM, L2 address mux).

## Interface
- `WORDS_PER_BLOCK`, default 4: beats per L2 block transfer; power of two, ≥2. `IDX_W = $clog2(WORDS_PER_BLOCK)`.
- `WRITE_ALLOCATE`, default 1: 1 means a store miss allocates the line then replays. 0 means a store miss is forwarded to L2 as one STORE beat and the cache is left untouched.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `pipe_req_valid` in 1: pipeline request present; held stable until fulfilled.
- `pipe_req_type` in `memory_operation_e`: LOAD, STORE or CLFLUSH.
- `pipe_req_fulfilled` out 1: one-cycle completion pulse.
- `valid_block_match` in 1: indexed line is valid and its tag matches.
- `victim_dirty` in 1: indexed line is valid and dirty, regardless of tag.
- `l2_req_valid` out 1: L2 request asserted.
- `l2_req_type` out `memory_operation_e`: type of the L2 request.
- `l2_req_fulfilled` in 1: L2 beat accepted or returned this cycle.
- `word_index` out `IDX_W`: beat number, used for data RAM and L2 address low bits.
- `l2_addr_sel_victim` out 1: 1 selects the victim tag for the L2 address; 0 selects the request tag.
- `load_mode` out 1: data RAM write source is L2.
- `perform_write` out 1: write the data RAM at `word_index` (or at the request word on a store hit).
- `set_dirty` out 1: set the dirty bit of the indexed line.
- `clear_selected_dirty_bit` out 1: clear the dirty bit of the indexed line.
- `clear_selected_valid_bit` out 1: clear the valid bit of the indexed line.
- `set_new_l2_block_address` out 1: latch the request block address.
- `finish_new_line_install` out 1: write tag, set valid, clear dirty.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, WRITEBACK, ALLOCATE, WRITE_AROUND. Enum values outside these drive all outputs to X and the next state to X.
- Internal registers: beat counter `cnt` (`IDX_W` bits) and `flush_q` (1 bit).
- IDLE with `pipe_req_valid` asserted:
  - CLFLUSH, no match: fulfilled.
  - CLFLUSH, match and clean: clear valid, fulfilled.
  - CLFLUSH, match and dirty: go to WRITEBACK with `flush_q=1`, `cnt=0`.
  - LOAD hit: fulfilled.
  - STORE hit: `perform_write`, `set_dirty`, fulfilled.
  - Miss with `victim_dirty`: go to WRITEBACK with `flush_q=0`, `cnt=0`, and pulse `set_new_l2_block_address`.
  - Miss with clean victim: go to ALLOCATE with `cnt=0`, and pulse `set_new_l2_block_address`.
  - STORE miss with `WRITE_ALLOCATE=0`: go to WRITE_AROUND, pulse `set_new_l2_block_address`, and ignore `victim_dirty`.
- WRITEBACK (Moore outputs: `l2_req_valid=1`, type STORE, `l2_addr_sel_victim=1`, `word_index=cnt`):
  - Each `l2_req_fulfilled` increments `cnt`.
  - On the fulfilled beat where `cnt==WORDS_PER_BLOCK-1`:
    - Pulse `clear_selected_dirty_bit`.
    - If `flush_q` is set: also clear valid, pulse fulfilled, go to IDLE.
    - Otherwise: go to ALLOCATE with `cnt` wrapped to 0.
- ALLOCATE (Moore outputs: `l2_req_valid=1`, type LOAD, `load_mode=1`, `word_index=cnt`):
  - Each `l2_req_fulfilled` pulses `perform_write` and increments `cnt`.
  - On the last beat, pulse `finish_new_line_install` and go to IDLE.
  - The request replays in IDLE the next cycle and hits.
- WRITE_AROUND (Moore outputs: `l2_req_valid=1`, type STORE, `l2_addr_sel_victim=0`):
  - On `l2_req_fulfilled`, pulse `pipe_req_fulfilled` and go to IDLE.
  - No array update.
- Counter arithmetic is modulo `WORDS_PER_BLOCK`. `cnt` wraps to 0 on the last beat.
- `l2_req_fulfilled` is ignored in IDLE.

## Timing
- Reset values: state IDLE, `cnt=0`, `flush_q=0`. In IDLE all outputs are 0, `l2_req_type=LOAD` and `word_index=0`.
- Reset asserted mid-transfer aborts the transfer: state returns to IDLE next edge and no dirty or valid update is issued.
- Hit: `pipe_req_fulfilled` in the same cycle, combinational from the inputs (Mealy).
- Clean miss: 1 IDLE cycle + `WORDS_PER_BLOCK` beats (each ≥1 cycle) + 1 replay cycle.
- Dirty miss: the clean-miss latency plus `WORDS_PER_BLOCK` write-back beats.
- A beat completes on each cycle where `l2_req_valid && l2_req_fulfilled`; back-to-back beats are allowed.
- Mealy outputs (`perform_write`, `clear_*`, `set_*`, `finish_*`, `pipe_req_fulfilled`) are single-cycle pulses.

## Structure
- `torrence_types` package:
  - Existing `memory_operation_e`.
  - New `dcache_state_e`, 2-bit.
- One sub-module, `beat_counter #(N)`:
  - Inputs: `clear`, `incr`.
  - Outputs: `count`, `last` (count==N-1).
- The FSM stays in `dcache_controller`, split into next-state/Mealy, Moore and state-register processes.

## Test plan
- LOAD hit (`valid_block_match=1`) -> `pipe_req_fulfilled=1` the same cycle; no L2 request.
- STORE hit -> `perform_write`, `set_dirty` and fulfilled, all in the same cycle.
- LOAD miss with a clean victim, W=4, L2 fulfilling every cycle:
  - 4 ALLOCATE beats with `word_index` 0,1,2,3 and `perform_write` on each.
  - `finish_new_line_install` on beat 3.
  - Fulfilled on the replay 6 cycles after the request.
- LOAD miss with a dirty victim, W=8, L2 fulfilling every other cycle:
  - 8 STORE beats with `l2_addr_sel_victim=1`, then `clear_selected_dirty_bit`.
  - Then 8 LOAD beats, then hit on replay.
- CLFLUSH on a dirty matching line -> 4 STORE beats, then `clear_selected_valid_bit`, `clear_selected_dirty_bit` and fulfilled together; no ALLOCATE.
- `WRITE_ALLOCATE=0` STORE miss -> one STORE beat, fulfilled on `l2_req_fulfilled`, no array writes. Separately, reset during ALLOCATE beat 2 -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
// Shared types for the data-cache controller and its neighbours.
// Request opcodes and controller state encoding.
package torrence_types;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        STORE   = 2'd1,
        CLFLUSH = 2'd2
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITEBACK    = 2'd1,
        ALLOCATE     = 2'd2,
        WRITE_AROUND = 2'd3
    } dcache_state_e;

endpackage

// File: rtl/dcache_controller_beat_counter.sv
// Beat counter for multi-word L2 block transfers.
// Wraps modulo N; last flags the final beat of a block.
module beat_counter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 incr,
    output logic [$clog2(N)-1:0] count,
    output logic                 last
);

    localparam int IW = $clog2(N);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == IW'(N - 1));

endmodule

// File: rtl/dcache_controller.sv
// Write-back data-cache controller: hit service, dirty victim write-back,
// block allocate with replay, dirty-aware flush and optional write-around.
module dcache_controller
    import torrence_types::*;
#(
    parameter int  WORDS_PER_BLOCK = 4,
    parameter bit  WRITE_ALLOCATE  = 1'b1,
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req_valid,
    input  memory_operation_e pipe_req_type,
    output logic              pipe_req_fulfilled,
    input  logic              valid_block_match,
    input  logic              victim_dirty,
    output logic              l2_req_valid,
    output memory_operation_e l2_req_type,
    input  logic              l2_req_fulfilled,
    output logic [IDX_W-1:0]  word_index,
    output logic              l2_addr_sel_victim,
    output logic              load_mode,
    output logic              perform_write,
    output logic              set_dirty,
    output logic              clear_selected_dirty_bit,
    output logic              clear_selected_valid_bit,
    output logic              set_new_l2_block_address,
    output logic              finish_new_line_install,
    output logic              busy
);

    dcache_state_e    state, state_nxt;
    logic             flush_q, flush_nxt;
    logic [IDX_W-1:0] cnt;
    logic             last;
    logic             cnt_clear, cnt_incr;
    logic             is_flush, is_mem, around;

    assign cnt_clear = (state == IDLE);
    assign cnt_incr  = l2_req_valid && l2_req_fulfilled
                     && (state != WRITE_AROUND);

    beat_counter #(.N(WORDS_PER_BLOCK)) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .count (cnt),
        .last  (last)
    );

    assign is_flush = (pipe_req_type == CLFLUSH);
    assign is_mem   = (pipe_req_type == LOAD) || (pipe_req_type == STORE);
    assign around   = (pipe_req_type == STORE) && !WRITE_ALLOCATE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt                = state;
        flush_nxt                = flush_q;
        pipe_req_fulfilled       = 1'b0;
        perform_write            = 1'b0;
        set_dirty                = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        clear_selected_valid_bit = 1'b0;
        set_new_l2_block_address = 1'b0;
        finish_new_line_install  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pipe_req_valid) begin
                    unique case (1'b1)
                        is_flush && !valid_block_match: begin
                            pipe_req_fulfilled = 1'b1;
                        end
                        is_flush && valid_block_match && !victim_dirty: begin
                            clear_selected_valid_bit = 1'b1;
                            pipe_req_fulfilled       = 1'b1;
                        end
                        is_flush && valid_block_match && victim_dirty: begin
                            state_nxt = WRITEBACK;
                            flush_nxt = 1'b1;
                        end
                        is_mem && valid_block_match: begin
                            pipe_req_fulfilled = 1'b1;
                            perform_write      = (pipe_req_type == STORE);
                            set_dirty          = (pipe_req_type == STORE);
                        end
                        is_mem && !valid_block_match && around: begin
                            set_new_l2_block_address = 1'b1;
                            state_nxt                = WRITE_AROUND;
                        end
                        is_mem && !valid_block_match && !around: begin
                            set_new_l2_block_address = 1'b1;
                            flush_nxt                = 1'b0;
                            state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
                        end
                        default: ;
                    endcase
                end
            end
            WRITEBACK: begin
                if (l2_req_fulfilled && last) begin
                    clear_selected_dirty_bit = 1'b1;
                    if (flush_q) begin
                        clear_selected_valid_bit = 1'b1;
                        pipe_req_fulfilled       = 1'b1;
                        state_nxt                = IDLE;
                    end else begin
                        state_nxt = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                if (l2_req_fulfilled) begin
                    perform_write = 1'b1;
                    if (last) begin
                        finish_new_line_install = 1'b1;
                        state_nxt               = IDLE;
                    end
                end
            end
            WRITE_AROUND: begin
                if (l2_req_fulfilled) begin
                    pipe_req_fulfilled = 1'b1;
                    state_nxt          = IDLE;
                end
            end
            default: begin
                state_nxt                = dcache_state_e'('x);
                flush_nxt                = 1'bx;
                pipe_req_fulfilled       = 1'bx;
                perform_write            = 1'bx;
                set_dirty                = 1'bx;
                clear_selected_dirty_bit = 1'bx;
                clear_selected_valid_bit = 1'bx;
                set_new_l2_block_address = 1'bx;
                finish_new_line_install  = 1'bx;
            end
        endcase
        // An aborted transfer must not leave a half-updated line behind.
        if (reset) begin
            pipe_req_fulfilled       = 1'b0;
            perform_write            = 1'b0;
            set_dirty                = 1'b0;
            clear_selected_dirty_bit = 1'b0;
            clear_selected_valid_bit = 1'b0;
            set_new_l2_block_address = 1'b0;
            finish_new_line_install  = 1'b0;
        end
    end

    always_comb begin
        l2_req_valid       = 1'b0;
        l2_req_type        = LOAD;
        word_index         = '0;
        l2_addr_sel_victim = 1'b0;
        load_mode          = 1'b0;
        busy               = (state != IDLE);
        unique case (state)
            IDLE: ;
            WRITEBACK: begin
                l2_req_valid       = 1'b1;
                l2_req_type        = STORE;
                l2_addr_sel_victim = 1'b1;
                word_index         = cnt;
            end
            ALLOCATE: begin
                l2_req_valid = 1'b1;
                load_mode    = 1'b1;
                word_index   = cnt;
            end
            WRITE_AROUND: begin
                l2_req_valid = 1'b1;
                l2_req_type  = STORE;
            end
            default: begin
                l2_req_valid       = 1'bx;
                l2_req_type        = memory_operation_e'('x);
                word_index         = 'x;
                l2_addr_sel_victim = 1'bx;
                load_mode          = 1'bx;
                busy               = 1'bx;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: three configurations driven in turn,
// checked every cycle against a transaction-level cache model.
module tb_dcache_controller;
    import torrence_types::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    memory_operation_e req_type  = LOAD;
    logic [3:0]        req_tag   = '0;
    logic              l2f       = 1'b0;
    int                fmode     = 0;
    int                sel       = 0;

    // Bench-side image of the indexed cache line.
    logic       line_valid = 1'b0;
    logic       line_dirty = 1'b0;
    logic [3:0] line_tag   = '0;
    logic       vbm, vd;
    assign vbm = line_valid && (line_tag == req_tag);
    assign vd  = line_valid && line_dirty;

    logic o_ful[3], o_l2v[3], o_vsel[3], o_lm[3], o_pw[3], o_sd[3];
    logic o_cd[3], o_cv[3], o_sa[3], o_fin[3], o_busy[3];
    memory_operation_e o_typ[3];
    logic [2:0] o_wi[3];

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W  = (k == 1) ? 8 : 4;
        localparam bit WA = (k == 2) ? 1'b0 : 1'b1;
        logic [$clog2(W)-1:0] wi;
        logic pvk;
        assign pvk = req_valid && (sel == k);
        assign o_wi[k] = 3'(wi);
        dcache_controller #(
            .WORDS_PER_BLOCK (W),
            .WRITE_ALLOCATE  (WA)
        ) u_dut (
            .clk                      (clk),
            .reset                    (reset),
            .pipe_req_valid           (pvk),
            .pipe_req_type            (req_type),
            .pipe_req_fulfilled       (o_ful[k]),
            .valid_block_match        (vbm),
            .victim_dirty             (vd),
            .l2_req_valid             (o_l2v[k]),
            .l2_req_type              (o_typ[k]),
            .l2_req_fulfilled         (l2f),
            .word_index               (wi),
            .l2_addr_sel_victim       (o_vsel[k]),
            .load_mode                (o_lm[k]),
            .perform_write            (o_pw[k]),
            .set_dirty                (o_sd[k]),
            .clear_selected_dirty_bit (o_cd[k]),
            .clear_selected_valid_bit (o_cv[k]),
            .set_new_l2_block_address (o_sa[k]),
            .finish_new_line_install  (o_fin[k]),
            .busy                     (o_busy[k])
        );
    end

    typedef struct {
        bit store;
        bit victim;
        int idx;
        bit last;
        bit flush;
        bit around;
    } beat_t;

    beat_t plan[$];
    int total = 0;
    int bad = 0;
    logic n_valid, n_dirty, n_done;
    logic [3:0] n_tag;
    int ob_sb, ob_lb, ob_pw;

    function automatic int cfg_w();
        return (sel == 1) ? 8 : 4;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cfg %0d, t=%0t)",
                     nm, act, exp, sel, $time);
        end
    endtask

    task automatic push_block(input bit store, input bit flush);
        for (int i = 0; i < cfg_w(); i++) begin
            plan.push_back('{store: store, victim: store, idx: i,
                             last: (i == cfg_w() - 1), flush: flush,
                             around: 1'b0});
        end
    endtask

    task automatic check();
        bit ev, esel, eload, epw, esd, ecd, ecv, esa, efin, eful, ebusy;
        bit hit, dty, pop;
        int eidx;
        memory_operation_e et;
        beat_t b;
        {ev, esel, eload, epw, esd, ecd, ecv, esa, efin, eful, pop} = '0;
        eidx  = 0;
        et    = LOAD;
        ebusy = (plan.size() != 0);
        hit   = line_valid && (line_tag == req_tag);
        dty   = line_valid && line_dirty;
        n_valid = line_valid;
        n_dirty = line_dirty;
        n_tag   = line_tag;
        if (plan.size() != 0) begin
            b     = plan[0];
            ev    = 1'b1;
            et    = b.store ? STORE : LOAD;
            esel  = b.victim;
            eload = !b.store;
            eidx  = b.idx;
            if (l2f) begin
                pop = 1'b1;
                if (!b.store) begin
                    epw = 1'b1;
                    if (b.last) begin
                        efin    = 1'b1;
                        n_valid = 1'b1;
                        n_tag   = req_tag;
                        n_dirty = 1'b0;
                    end
                end
                if (b.victim && b.last) begin
                    ecd     = 1'b1;
                    n_dirty = 1'b0;
                    if (b.flush) begin
                        ecv     = 1'b1;
                        eful    = 1'b1;
                        n_valid = 1'b0;
                    end
                end
                if (b.around) eful = 1'b1;
            end
        end else if (req_valid) begin
            if (req_type == CLFLUSH) begin
                if (!hit) begin
                    eful = 1'b1;
                end else if (!dty) begin
                    ecv     = 1'b1;
                    eful    = 1'b1;
                    n_valid = 1'b0;
                end else begin
                    push_block(1'b1, 1'b1);
                end
            end else if (hit) begin
                eful = 1'b1;
                if (req_type == STORE) begin
                    epw     = 1'b1;
                    esd     = 1'b1;
                    n_dirty = 1'b1;
                end
            end else if (req_type == STORE && sel == 2) begin
                esa = 1'b1;
                plan.push_back('{store: 1'b1, victim: 1'b0, idx: 0,
                                 last: 1'b1, flush: 1'b0, around: 1'b1});
            end else begin
                esa = 1'b1;
                if (dty) push_block(1'b1, 1'b0);
                push_block(1'b0, 1'b0);
            end
        end
        n_done = eful;
        cmp("fulfilled", int'(o_ful[sel]), int'(eful));
        cmp("l2_valid", int'(o_l2v[sel]), int'(ev));
        cmp("l2_type", int'(o_typ[sel]), int'(et));
        cmp("word_index", int'(o_wi[sel]), eidx);
        cmp("sel_victim", int'(o_vsel[sel]), int'(esel));
        cmp("load_mode", int'(o_lm[sel]), int'(eload));
        cmp("perform_write", int'(o_pw[sel]), int'(epw));
        cmp("set_dirty", int'(o_sd[sel]), int'(esd));
        cmp("clear_dirty", int'(o_cd[sel]), int'(ecd));
        cmp("clear_valid", int'(o_cv[sel]), int'(ecv));
        cmp("set_addr", int'(o_sa[sel]), int'(esa));
        cmp("finish", int'(o_fin[sel]), int'(efin));
        cmp("busy", int'(o_busy[sel]), int'(ebusy));
        if (o_l2v[sel] && l2f) begin
            if (o_typ[sel] == STORE) ob_sb++;
            else ob_lb++;
        end
        if (o_pw[sel]) ob_pw++;
        if (pop) void'(plan.pop_front());
    endtask

    task automatic cycle();
        bit checked;
        checked = 1'b0;
        @(negedge clk);
        if (!reset) begin
            check();
            checked = 1'b1;
        end
        @(posedge clk);
        #1;
        if (checked) begin
            line_valid = n_valid;
            line_dirty = n_dirty;
            line_tag   = n_tag;
            if (n_done) req_valid = 1'b0;
        end
        case (fmode)
            0:       l2f = 1'b1;
            1:       l2f = ~l2f;
            default: l2f = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        plan.delete();
    endtask

    task automatic run_req(input memory_operation_e t, input logic [3:0] tag,
                           input int maxc, output int lat);
        req_type  = t;
        req_tag   = tag;
        req_valid = 1'b1;
        lat   = 0;
        ob_sb = 0;
        ob_lb = 0;
        ob_pw = 0;
        while (req_valid && lat < maxc) begin
            cycle();
            lat++;
        end
        if (req_valid) begin
            total++;
            bad++;
            $display("FAIL timeout: request still pending after %0d cycles",
                     maxc);
            do_reset();
        end
    endtask

    task automatic preset(input bit v, input bit d, input logic [3:0] t);
        line_valid = v;
        line_dirty = d;
        line_tag   = t;
    endtask

    initial begin
        int lat;
        int r;
        memory_operation_e t;
        repeat (2) cycle();
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cmp("rst_busy", int'(o_busy[k]), 0);
            cmp("rst_l2_valid", int'(o_l2v[k]), 0);
            cmp("rst_l2_type", int'(o_typ[k]), int'(LOAD));
            cmp("rst_word_index", int'(o_wi[k]), 0);
        end
        @(posedge clk);
        #1;

        sel = 0;
        fmode = 0;
        preset(1'b1, 1'b0, 4'd5);
        run_req(LOAD, 4'd5, 50, lat);
        cmp("load_hit_latency", lat, 1);
        cmp("load_hit_l2_beats", ob_sb + ob_lb, 0);
        run_req(STORE, 4'd5, 50, lat);
        cmp("store_hit_latency", lat, 1);
        cmp("store_hit_writes", ob_pw, 1);
        preset(1'b1, 1'b0, 4'd5);
        run_req(LOAD, 4'd6, 50, lat);
        cmp("clean_miss_latency", lat, 6);
        cmp("clean_miss_load_beats", ob_lb, 4);
        cmp("clean_miss_writes", ob_pw, 4);
        run_req(STORE, 4'd6, 50, lat);
        run_req(CLFLUSH, 4'd6, 50, lat);
        cmp("flush_latency", lat, 5);
        cmp("flush_store_beats", ob_sb, 4);
        cmp("flush_load_beats", ob_lb, 0);
        cmp("flush_line_valid", int'(line_valid), 0);

        sel = 1;
        fmode = 1;
        preset(1'b1, 1'b1, 4'd1);
        run_req(LOAD, 4'd2, 100, lat);
        cmp("dirty_miss_store_beats", ob_sb, 8);
        cmp("dirty_miss_load_beats", ob_lb, 8);

        sel = 2;
        fmode = 0;
        preset(1'b1, 1'b1, 4'd3);
        run_req(STORE, 4'd4, 50, lat);
        cmp("around_latency", lat, 2);
        cmp("around_store_beats", ob_sb, 1);
        cmp("around_writes", ob_pw, 0);
        cmp("around_line_tag", int'(line_tag), 3);

        sel = 0;
        fmode = 0;
        preset(1'b0, 1'b0, 4'd0);
        req_type  = LOAD;
        req_tag   = 4'd7;
        req_valid = 1'b1;
        repeat (3) cycle();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        cmp("abort_word_index", int'(o_wi[0]), 2);
        cmp("abort_clear_dirty", int'(o_cd[0]), 0);
        cmp("abort_clear_valid", int'(o_cv[0]), 0);
        cmp("abort_finish", int'(o_fin[0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        plan.delete();
        @(negedge clk);
        cmp("abort_busy", int'(o_busy[0]), 0);
        cmp("abort_l2_valid", int'(o_l2v[0]), 0);
        cmp("abort_word_index_idle", int'(o_wi[0]), 0);
        cmp("abort_perform_write", int'(o_pw[0]), 0);
        cmp("abort_load_mode", int'(o_lm[0]), 0);
        @(posedge clk);
        #1;

        for (int s = 0; s < 3; s++) begin
            sel   = s;
            fmode = 2;
            preset(1'b0, 1'b0, 4'd0);
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 2)) cycle();
                r = $urandom_range(0, 9);
                t = (r < 4) ? LOAD : (r < 8) ? STORE : CLFLUSH;
                run_req(t, 4'($urandom_range(0, 1)), 200, lat);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
